// File: rtl/decode_ctrl_stage.sv
// Registered decode stage between fetch and execute.
// Turns a 16-entry opcode set into a registered control bundle behind a
// valid/ready handshake. It also inserts load-use bubbles, holds execute for
// multi-cycle multiplies, squashes the branch shadow and flags illegal opcodes.
module decode_ctrl_stage #(
    parameter int unsigned OPW         = 4,
    parameter int unsigned RW          = 2,
    parameter int unsigned MUL_CYCLES  = 2,
    parameter int unsigned FLUSH_SLOTS = 1,
    parameter int unsigned HAZARD_EN   = 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          i_valid,
    input  logic [OPW-1:0] i_opcode,
    input  logic [RW-1:0] i_rd,
    input  logic [RW-1:0] i_rs1,
    input  logic [RW-1:0] i_rs2,
    input  logic          i_ex_ready,
    output logic          o_ready,
    output logic          o_valid,
    output logic [1:0]    o_alufunc,
    output logic          o_branch,
    output logic          o_flush,
    output logic          o_regwrite,
    output logic          o_memwrite,
    output logic          o_memtoreg,
    output logic          o_immediate,
    output logic          o_forward,
    output logic [RW-1:0] o_rd,
    output logic          o_illegal,
    output logic          o_busy
);

    // The counter must hold either the multiply hold count or the flush count.
    localparam int unsigned CNT_MAX = (MUL_CYCLES > FLUSH_SLOTS) ? MUL_CYCLES : FLUSH_SLOTS;
    localparam int unsigned CW      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

    // Opcode map (low four bits)
    localparam logic [3:0] OP_LDA     = 4'h0;
    localparam logic [3:0] OP_STA     = 4'h1;
    localparam logic [3:0] OP_CAL_ADD = 4'h2;
    localparam logic [3:0] OP_CAL_SUB = 4'h3;
    localparam logic [3:0] OP_CAL_MUL = 4'h4;
    localparam logic [3:0] OP_CAL_SLT = 4'h5;
    localparam logic [3:0] OP_IMM_ADD = 4'h6;
    localparam logic [3:0] OP_IMM_SUB = 4'h7;
    localparam logic [3:0] OP_IMM_MUL = 4'h8;
    localparam logic [3:0] OP_BAF_IMM = 4'h9;
    localparam logic [3:0] OP_BAF_REG = 4'hA;
    localparam logic [3:0] OP_NONE    = 4'hF;

    // Control bundle, most significant field first
    typedef struct packed {
        logic [1:0] alufunc;
        logic       branch;
        logic       flush;
        logic       regwrite;
        logic       memwrite;
        logic       memtoreg;
        logic       immediate;
        logic       forward;
    } ctrl_t;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MUL_WAIT = 2'd1,
        ST_FLUSH    = 2'd2
    } state_t;

    // Registered state
    state_t          state;
    logic [CW-1:0]   cnt;
    ctrl_t           ctrl_q;
    logic            valid_q;
    logic [RW-1:0]   rd_q;
    logic            illegal_q;

    // Next-state values
    state_t          state_nx;
    logic [CW-1:0]   cnt_nx;
    ctrl_t           ctrl_nx;
    logic            valid_nx;
    logic [RW-1:0]   rd_nx;
    logic            illegal_nx;

    // Decoder results
    logic [3:0]      op_lo;
    logic            op_hi_set;
    ctrl_t           dec_ctrl;
    logic            dec_legal;
    logic            dec_mul;
    logic            dec_branch;
    logic            reads_rs1;
    logic            reads_rs2;

    logic            hazard;
    logic            ready_c;
    logic            accept;

    assign op_lo     = i_opcode[3:0];
    assign op_hi_set = (i_opcode >> 4) != '0;

    // Opcode decode into control bundle plus register-read and sequencing flags
    always_comb begin
        dec_ctrl   = '0;
        dec_legal  = 1'b0;
        dec_mul    = 1'b0;
        dec_branch = 1'b0;
        reads_rs1  = 1'b0;
        reads_rs2  = 1'b0;
        if (!op_hi_set) begin
            case (op_lo)
                OP_LDA: begin
                    dec_ctrl  = ctrl_t'(9'b00_0010111);
                    dec_legal = 1'b1;
                end
                OP_STA: begin
                    dec_ctrl  = ctrl_t'(9'b00_0001010);
                    dec_legal = 1'b1;
                    reads_rs1 = 1'b1;
                end
                OP_CAL_ADD, OP_CAL_SUB, OP_CAL_MUL, OP_CAL_SLT: begin
                    dec_ctrl  = ctrl_t'({2'(op_lo - OP_CAL_ADD), 7'b0010001});
                    dec_legal = 1'b1;
                    dec_mul   = (op_lo == OP_CAL_MUL);
                    reads_rs1 = 1'b1;
                    reads_rs2 = 1'b1;
                end
                OP_IMM_ADD, OP_IMM_SUB, OP_IMM_MUL: begin
                    dec_ctrl  = ctrl_t'({2'(op_lo - OP_IMM_ADD), 7'b0010011});
                    dec_legal = 1'b1;
                    dec_mul   = (op_lo == OP_IMM_MUL);
                    reads_rs1 = 1'b1;
                end
                OP_BAF_IMM: begin
                    dec_ctrl   = ctrl_t'(9'b01_1100010);
                    dec_legal  = 1'b1;
                    dec_branch = 1'b1;
                    reads_rs1  = 1'b1;
                end
                OP_BAF_REG: begin
                    dec_ctrl   = ctrl_t'(9'b01_1100000);
                    dec_legal  = 1'b1;
                    dec_branch = 1'b1;
                    reads_rs1  = 1'b1;
                    reads_rs2  = 1'b1;
                end
                OP_NONE: begin
                    dec_ctrl  = '0;
                    dec_legal = 1'b1;
                end
                default: begin
                    dec_ctrl  = '0;
                    dec_legal = 1'b0;
                end
            endcase
        end
    end

    // Load-use hazard: the load in the output register feeds a source the incoming op reads
    always_comb begin
        hazard = 1'b0;
        if ((HAZARD_EN != 0) && valid_q && ctrl_q.memtoreg && ctrl_q.regwrite) begin
            hazard = (reads_rs1 && (rd_q == i_rs1)) || (reads_rs2 && (rd_q == i_rs2));
        end
    end

    assign ready_c = i_ex_ready && (state != ST_MUL_WAIT) && !hazard;
    assign accept  = i_valid && ready_c;

    // Next-state and next-output selection; a bubble is the default update
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        ctrl_nx    = '0;
        valid_nx   = 1'b0;
        rd_nx      = '0;
        illegal_nx = 1'b0;
        case (state)
            ST_RUN: begin
                if (accept) begin
                    if (dec_legal) begin
                        ctrl_nx  = dec_ctrl;
                        valid_nx = 1'b1;
                        rd_nx    = i_rd;
                        if (dec_mul && (MUL_CYCLES > 1)) begin
                            state_nx = ST_MUL_WAIT;
                            cnt_nx   = CW'(MUL_CYCLES - 1);
                        end
                        if (dec_branch && (FLUSH_SLOTS > 0)) begin
                            state_nx = ST_FLUSH;
                            cnt_nx   = CW'(FLUSH_SLOTS);
                        end
                    end else begin
                        illegal_nx = 1'b1;
                    end
                end
            end
            ST_MUL_WAIT: begin
                cnt_nx = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_nx = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (accept) begin
                    cnt_nx = cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state_nx = ST_RUN;
                    end
                end
            end
            default: begin
                state_nx = ST_RUN;
                cnt_nx   = '0;
            end
        endcase
    end

    // State and output registers; execute backpressure freezes everything
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= ST_RUN;
            cnt       <= '0;
            ctrl_q    <= '0;
            valid_q   <= 1'b0;
            rd_q      <= '0;
            illegal_q <= 1'b0;
        end else if (i_ex_ready) begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            ctrl_q    <= ctrl_nx;
            valid_q   <= valid_nx;
            rd_q      <= rd_nx;
            illegal_q <= illegal_nx;
        end
    end

    assign o_ready     = ready_c;
    assign o_valid     = valid_q;
    assign o_alufunc   = ctrl_q.alufunc;
    assign o_branch    = ctrl_q.branch;
    assign o_flush     = ctrl_q.flush;
    assign o_regwrite  = ctrl_q.regwrite;
    assign o_memwrite  = ctrl_q.memwrite;
    assign o_memtoreg  = ctrl_q.memtoreg;
    assign o_immediate = ctrl_q.immediate;
    assign o_forward   = ctrl_q.forward;
    assign o_rd        = rd_q;
    assign o_illegal   = illegal_q;
    assign o_busy      = (state != ST_RUN);

endmodule

// File: doc/decode_ctrl_stage.md
Name: decode_ctrl_stage

Overview:
Registered, parametrised successor to the combinational opcode decoder. It sits between fetch and execute and decodes the same 16-bit ISA opcode set into a registered control bundle, with a valid/ready handshake. It adds sequencing the combinational decoder lacks: load-use hazard bubbles, a multi-cycle multiply hold, branch-shadow squashing, and illegal-opcode reporting.

Parameters:
OPW, 4, opcode width; opcodes with any bit above [3:0] set are illegal.
RW, 2, register-index width for rd/rs1/rs2.
MUL_CYCLES, 2, total cycles a multiply occupies execute (at least 1).
FLUSH_SLOTS, 1, instructions squashed after an accepted branch (0 to 3).
HAZARD_EN, 1, 1 enables load-use bubble insertion.

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
i_valid  in  1  fetch presents an instruction
i_opcode  in  OPW  opcode
i_rd  in  RW  destination register
i_rs1  in  RW  source 1
i_rs2  in  RW  source 2
i_ex_ready  in  1  execute can accept; 0 freezes all output registers
o_ready  out  1  decode accepts the instruction this cycle
o_valid  out  1  registered bundle is a real instruction
o_alufunc  out  2  00 add, 01 sub, 10 mul, 11 slt
o_branch, o_flush, o_regwrite, o_memwrite, o_memtoreg, o_immediate, o_forward  out  1 each  registered controls
o_rd  out  RW  registered destination
o_illegal  out  1  one-cycle pulse on a consumed illegal opcode
o_busy  out  1  state is not RUN

Behaviour:
- Reset (reset_n=0 at a clk edge): every output register is 0, the state is RUN and the counters are 0. Reset applies mid-multiply or mid-flush and aborts the sequence.
- Decode table, in field order alufunc,branch,flush,regwrite,memwrite,memtoreg,immediate,forward:
  - 0000 LDA = 00_0010111
  - 0001 STA = 00_0001010
  - 0010/0011/0100/0101 CAL add/sub/mul/slt = alufunc 00/01/10/11 with _0010001
  - 0110/0111/1000 IMM add/sub/mul = alufunc 00/01/10 with _0010011
  - 1001 BAF_imm = 01_1100010
  - 1010 BAF_reg = 01_1100000
  - 1111 NONE = all zero; o_valid=1
  - 1011 to 1110 are illegal.
- Register reads: CAL_* and BAF_reg read rs1 and rs2. IMM_*, STA and BAF_imm read rs1 only. LDA and NONE read nothing.
- Hazard: asserted when HAZARD_EN=1, o_valid=1, o_memtoreg=1, o_regwrite=1, and o_rd equals a source register the incoming op reads.
- o_ready = i_ex_ready & (state != MUL_WAIT) & ~hazard. An instruction is accepted when i_valid & o_ready.
- Output update: outputs update only on cycles with i_ex_ready=1; when i_ex_ready=0 all outputs hold, including o_illegal.
  - On an update, an accepted legal op loads its decoded bundle plus i_rd with o_valid=1.
  - Any other update loads a bubble: o_valid=0 and all controls 0.
- Latency: one cycle from acceptance to the bundle appearing on the outputs.
- RUN state:
  - Accepted CAL_mul or IMM_mul with MUL_CYCLES>1 enters MUL_WAIT with counter = MUL_CYCLES-1.
  - Accepted BAF_* with FLUSH_SLOTS>0 enters FLUSH with counter = FLUSH_SLOTS.
  - A hazard cycle produces exactly one bubble. The next cycle o_valid=0, so the hazard clears.
- MUL_WAIT:
  - o_ready=0; each i_ex_ready cycle emits a bubble and decrements the counter.
  - At counter 1, the decrement returns the state to RUN, so exactly MUL_CYCLES-1 bubbles follow the mul bundle.
- FLUSH:
  - o_ready follows i_ex_ready; each accepted instruction is consumed but emitted as a bubble, and the counter decrements.
  - Cycles with i_valid=0 do not decrement.
  - Return to RUN when the counter reaches 0.
  - Squashed ops never raise o_illegal or enter MUL_WAIT.
- Illegal opcode in RUN: it is consumed, a bubble is emitted, and o_illegal=1 for that update only. No state change.
- Simultaneous events: i_ex_ready=0 overrides everything, so there are no state or counter changes. Hazard and mul on the same op: the bubble comes first, then the mul is accepted normally.

Test Plan:
- Reset and decode table: release reset, then stream all 16 opcodes with rs equal to none of rd. Each legal op's bundle appears one cycle later matching the table (e.g. CAL_sub gives alufunc=01, regwrite=1, forward=1). Opcodes 1011 to 1110 give o_valid=0 plus an o_illegal pulse. Reset mid-stream gives all outputs 0 on the next edge.
- Load-use: LDA rd=2, then CAL_add rs2=2. There is one cycle with o_ready=0 and o_valid=0, then the CAL bundle. Repeat with HAZARD_EN=0: no bubble. Repeat with rs1=rs2=1: no bubble.
- Multiply: MUL_CYCLES=3, CAL_mul then IMM_add back-to-back. The mul bundle is followed by 2 bubbles with o_busy=1 and o_ready=0, then the IMM_add bundle. MUL_CYCLES=1 gives no bubbles.
- Branch shadow: FLUSH_SLOTS=2, BAF_reg then LDA, idle, STA, CAL_add. The branch bundle (branch=1, flush=1) is followed by bubbles for LDA and STA (the idle cycle does not count), then the CAL_add bundle.
- Backpressure: hold i_ex_ready=0 for 3 cycles during MUL_WAIT and during an o_illegal pulse. Outputs, counters and o_illegal hold unchanged, and the sequence resumes exactly when i_ex_ready returns to 1.
- Reset mid-FLUSH and mid-MUL_WAIT: the next edge gives state RUN, o_busy=0 and o_valid=0, and the first op after reset decodes normally.
